// File: rtl/dma_pkg.sv
// dma_pkg: shared DMA register addresses, mask-bit meaning and field-width helper
package dma_pkg;
   localparam int         ADDR_W      = 4;
   localparam logic [3:0] ADDR_SINGLE = 4'hA;
   localparam logic [3:0] ADDR_MCLR   = 4'hD;
   localparam logic [3:0] ADDR_CLEAR  = 4'hE;
   localparam logic [3:0] ADDR_ALL    = 4'hF;
   localparam logic       MASK_SET    = 1'b1;

   function automatic int sel_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction
endpackage

// File: rtl/dma_mask_register_ex_if.sv
// dma_mask_register_ex_if: CPU-side register bus (chip select, strobes, address, data)
interface dma_mask_register_ex_if import dma_pkg::*; #(parameter int DATA_W = 8);
   logic              CS;
   logic              IOR;
   logic              IOW;
   logic [ADDR_W-1:0] address_in;
   logic [DATA_W-1:0] data_in;
   logic [DATA_W-1:0] data_out;
   logic              data_oe;

   modport master (output CS, IOR, IOW, address_in, data_in, input data_out, data_oe);
   modport slave  (input CS, IOR, IOW, address_in, data_in, output data_out, data_oe);
endinterface

// File: rtl/io_strobe_edge.sv
// io_strobe_edge: one-cycle pulse on the first cycle of a qualified I/O strobe
module io_strobe_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic i_level,
   output logic o_stb
);
   logic r_level;
   logic r_armed;

   // track last cycle's strobe; the first cycle after reset is never an edge, so a strobe held through reset is ignored
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_level <= 1'b0;
         r_armed <= 1'b0;
      end else begin
         r_level <= i_level;
         r_armed <= 1'b1;
      end

   assign o_stb = i_level & ~r_level & r_armed;
endmodule

// File: rtl/dma_mask_register_ex.sv
// dma_mask_register_ex: per-channel DMA mask with CPU commands, read-back and terminal-count auto-masking
module dma_mask_register_ex import dma_pkg::*; #(
   parameter int NUM_CH = 4,
   parameter int DATA_W = 8
) (
   input  logic                   CLK,
   input  logic                   reset,
   dma_mask_register_ex_if.slave  bus,
   input  logic [NUM_CH-1:0]      tc,
   input  logic [NUM_CH-1:0]      autoInit,
   output logic [NUM_CH-1:0]      maskedChannels
);
   localparam int SEL_W = sel_w(NUM_CH);

   logic [NUM_CH-1:0] r_mask;
   logic [NUM_CH-1:0] w_cmd_next;
   logic [NUM_CH-1:0] w_onehot;
   logic [SEL_W-1:0]  w_ch;
   logic [DATA_W-1:0] r_dout;
   logic              r_oe;
   logic              w_wr_lvl;
   logic              w_wr_stb;
   logic              w_rd;
   logic              w_unused;

   assign w_wr_lvl = ~bus.CS & ~bus.IOW & bus.IOR;
   assign w_rd     = ~bus.CS & ~bus.IOR & bus.IOW & (bus.address_in == ADDR_ALL);

   io_strobe_edge u_wr_edge (
      .clk    (CLK),
      .rst_n  (reset),
      .i_level(w_wr_lvl),
      .o_stb  (w_wr_stb)
   );

   // an out-of-range channel index shifts the one-hot out of the vector, leaving the mask untouched
   assign w_ch     = bus.data_in[SEL_W-1:0];
   assign w_onehot = NUM_CH'(1) << w_ch;

   // command decode on the write strobe
   always_comb begin
      w_cmd_next = r_mask;
      if (w_wr_stb)
         case (bus.address_in)
            ADDR_SINGLE: w_cmd_next = (bus.data_in[SEL_W] == MASK_SET) ? (r_mask | w_onehot) : (r_mask & ~w_onehot);
            ADDR_ALL:    w_cmd_next = bus.data_in[NUM_CH-1:0];
            ADDR_CLEAR:  w_cmd_next = '0;
            ADDR_MCLR:   w_cmd_next = '1;
            default:     w_cmd_next = r_mask;
         endcase
   end

   // mask state; terminal count on a non-autoinit channel overrides any same-cycle clear
   always_ff @(posedge CLK or negedge reset)
      if (!reset) r_mask <= '1;
      else        r_mask <= w_cmd_next | (tc & ~autoInit);

   // registered read-back of the mask as it stood before this edge's update
   always_ff @(posedge CLK or negedge reset)
      if (!reset) begin
         r_oe   <= 1'b0;
         r_dout <= '0;
      end else begin
         r_oe   <= w_rd;
         r_dout <= w_rd ? DATA_W'(r_mask) : '0;
      end

   assign bus.data_out   = r_dout;
   assign bus.data_oe    = r_oe;
   assign maskedChannels = r_mask;
   assign w_unused       = ^bus.data_in;
endmodule
